// File: rtl/husky_adc_spi.sv
// husky_adc_spi: single-command SPI engine for the ADS4128 configuration port.
// Optional ADC hardware-reset sequencer after reset_i, enabled by ADC_SPI_RESET_SEQ_EN.
module husky_adc_spi #(
  parameter int pCLKDIV = 4,
  parameter int pRST_CYCLES = 64
) (
  input  logic       clk_usb,
  input  logic       reset_i,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ADC_SEN,
  output logic       ADC_SCLK,
  output logic       ADC_SDATA,
  input  logic       ADC_OVR_SDOUT,
  output logic       ADC_RESET
);
  if (pCLKDIV < 1 || pCLKDIV > 255 || pRST_CYCLES < 1 || pRST_CYCLES > 65535) begin : g_bad_param
    $error("husky_adc_spi: parameter out of range");
  end
`ifdef ADC_SPI_RESET_SEQ_EN
  typedef enum logic [2:0] {IDLE, SETUP, HI, LO, HOLD, RSTPULSE} state_t;
  localparam state_t RST_STATE = RSTPULSE;
  logic [16:0] rcnt;
`else
  typedef enum logic [2:0] {IDLE, SETUP, HI, LO, HOLD} state_t;
  localparam state_t RST_STATE = IDLE;
`endif
  state_t st, st_n;
  logic [7:0] div, div_n, rx, rx_n, rdata_n;
  logic [3:0] bitc, bitc_n;
  logic [15:0] word, word_n;
  logic rw_q, rw_n, pend, cap, tick, done_n;
  assign tick = div == 8'(pCLKDIV - 1);
  // A command is latched one cycle before the FSM leaves IDLE, so SEN falls the edge after start.
  always_comb begin
    cap = start && st == IDLE && !pend;
    st_n = st;
    div_n = tick ? 8'd0 : div + 8'd1;
    bitc_n = bitc;
    word_n = cap ? {addr, rw ? 8'h00 : wdata} : word;
    rw_n = cap ? rw : rw_q;
    rx_n = rx;
    rdata_n = rdata;
    done_n = 1'b0;
    if (st == IDLE) begin
      div_n = 8'd0;
      if (pend) st_n = SETUP;
    end
`ifdef ADC_SPI_RESET_SEQ_EN
    else if (st == RSTPULSE) begin
      div_n = 8'd0;
      if (rcnt == 17'(2 * pRST_CYCLES)) st_n = IDLE;
    end
`endif
    else if (tick) begin
      if (st == SETUP) begin
        st_n = HI;
        bitc_n = 4'd15;
      end else if (st == HI) begin
        st_n = LO;
      end else if (st == LO) begin
        if (rw_q && !bitc[3]) rx_n = {rx[6:0], ADC_OVR_SDOUT};
        if (bitc == 4'd0) st_n = HOLD;
        else begin
          st_n = HI;
          bitc_n = bitc - 4'd1;
          word_n = {word[14:0], 1'b0};
        end
      end else if (st == HOLD) begin
        st_n = IDLE;
        done_n = 1'b1;
        if (rw_q) rdata_n = rx;
      end
    end
  end
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      st <= RST_STATE;
      div <= 8'd0;
      bitc <= 4'd0;
      word <= 16'd0;
      rx <= 8'd0;
      rdata <= 8'd0;
      rw_q <= 1'b0;
      pend <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      ADC_SEN <= 1'b1;
      ADC_SCLK <= 1'b1;
      ADC_SDATA <= 1'b0;
    end else begin
      st <= st_n;
      div <= div_n;
      bitc <= bitc_n;
      word <= word_n;
      rx <= rx_n;
      rdata <= rdata_n;
      rw_q <= rw_n;
      pend <= cap;
      busy <= st_n != IDLE;
      done <= done_n;
      ADC_SEN <= !(st_n inside {SETUP, HI, LO, HOLD});
      ADC_SCLK <= st_n != LO;
      ADC_SDATA <= (st_n == HI || st_n == LO) && word_n[15];
    end
  end
`ifdef ADC_SPI_RESET_SEQ_EN
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      rcnt <= 17'd0;
      ADC_RESET <= 1'b0;
    end else begin
      rcnt <= st == RSTPULSE ? rcnt + 17'd1 : rcnt;
      ADC_RESET <= st_n == RSTPULSE && rcnt < 17'(pRST_CYCLES);
    end
  end
`else
  assign ADC_RESET = 1'b0;
`endif
endmodule

// File: tb/tb_husky_adc_spi.sv
// tb_husky_adc_spi: randomized self-checking bench for husky_adc_spi (pCLKDIV=2, pRST_CYCLES=8).
module tb_husky_adc_spi;
  localparam int P = 2;
  localparam int NR = 8;
  localparam int LEN = 34 * P + 4;
`ifdef ADC_SPI_RESET_SEQ_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif
  logic clk_usb = 1'b0, reset_i = 1'b1, start = 1'b0, rw = 1'b0, sdout = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic [7:0] rdata;
  logic busy, done, sen, sclk, sdata, adc_rst;
  int checks = 0, failures = 0;
  logic [7:0] model_rdata = 8'h00;
  logic [15:0] m_word;
  int m_falls, m_first_fall, m_sen_low, m_done_cnt, m_done_edge;
  logic m_busy_at_done;
  logic [7:0] m_rdata_at_done;
  logic [13:0] m_snap;

  husky_adc_spi #(.pCLKDIV(P), .pRST_CYCLES(NR)) dut (
    .clk_usb(clk_usb), .reset_i(reset_i), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .ADC_SEN(sen), .ADC_SCLK(sclk), .ADC_SDATA(sdata),
    .ADC_OVR_SDOUT(sdout), .ADC_RESET(adc_rst)
  );

  always #5 clk_usb = ~clk_usb;

  // Drives one command, plays the ADC's SDOUT role and measures the serial waveform at a transaction level.
  task automatic run_xfer(input logic r, input logic [7:0] a, input logic [7:0] d, input logic [7:0] so,
                          input int inj_start, input int inj_reset);
    logic prev;
    m_word = 16'h0; m_falls = 0; m_first_fall = -1; m_sen_low = 0; m_done_cnt = 0; m_done_edge = -1;
    m_busy_at_done = 1'bx; m_rdata_at_done = 8'hxx;
    @(negedge clk_usb);
    start = 1'b1; rw = r; addr = a; wdata = d;
    @(posedge clk_usb);
    #1 start = 1'b0; rw = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
    prev = sclk;
    for (int e = 1; e <= LEN; e++) begin
      @(posedge clk_usb);
      #1;
      if (start) start = 1'b0;
      if (prev && !sclk) begin
        m_word = {m_word[14:0], sdata};
        m_falls++;
        if (m_first_fall < 0) m_first_fall = e;
        sdout = (m_falls >= 9 && m_falls <= 16) ? so[16 - m_falls] : 1'($urandom);
      end
      prev = sclk;
      if (!sen) m_sen_low++;
      if (done) begin
        m_done_cnt++;
        if (m_done_edge < 0) begin
          m_done_edge = e; m_busy_at_done = busy; m_rdata_at_done = rdata;
        end
      end
      if (e == inj_start) begin
        start = 1'b1; rw = 1'b1; addr = 8'hFF; wdata = 8'h00;
      end
      if (e == inj_reset) begin
        reset_i = 1'b1;
        #1 m_snap = {sen, sclk, sdata, busy, done, adc_rst, rdata};
      end
      if (inj_reset > 0 && e == inj_reset + 2) begin
        reset_i = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    repeat (2) @(posedge clk_usb);
    for (int n = 0; n < 200 && busy; n++) begin
      @(posedge clk_usb);
      #1;
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL wait_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_usb);
    #1;
    checks++;
    if ({sen, sclk, sdata, busy, done, adc_rst, rdata} !== {6'b110000, 8'h00}) begin
      failures++;
      $display("FAIL reset_values got=%b exp=%b", {sen, sclk, sdata, busy, done, adc_rst, rdata}, {6'b110000, 8'h00});
    end
  endtask

  task automatic test_reset_seq();
    int hi = 0, bz = 0, first_hi = -1, sl = 0, dn = 0;
    @(posedge clk_usb);
    #1 reset_i = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk_usb);
      #1;
      if (start) start = 1'b0;
      if (adc_rst) begin hi++; if (first_hi < 0) first_hi = e; end
      if (busy) bz++;
      if (!sen) sl++;
      if (done) dn++;
      if (SEQ && e == 4) begin start = 1'b1; rw = 1'b0; addr = 8'($urandom); wdata = 8'($urandom); end
    end
    checks++;
    if (hi !== (SEQ ? NR : 0)) begin failures++; $display("FAIL seq_reset_len got=%0d exp=%0d", hi, SEQ ? NR : 0); end
    checks++;
    if (first_hi !== (SEQ ? 1 : -1)) begin failures++; $display("FAIL seq_reset_first got=%0d exp=%0d", first_hi, SEQ ? 1 : -1); end
    checks++;
    if (bz !== (SEQ ? 2 * NR : 0)) begin failures++; $display("FAIL seq_busy_len got=%0d exp=%0d", bz, SEQ ? 2 * NR : 0); end
    checks++;
    if (sl !== 0 || dn !== 0) begin failures++; $display("FAIL seq_start_ignored sen_low=%0d done=%0d exp=0,0", sl, dn); end
  endtask

  task automatic test_write();
    run_xfer(1'b0, 8'h55, 8'hAA, 8'($urandom), -1, -1);
    checks++;
    if (m_word !== 16'h55AA) begin failures++; $display("FAIL write_bits got=%h exp=55aa", m_word); end
    checks++;
    if (m_falls !== 16) begin failures++; $display("FAIL write_falls got=%0d exp=16", m_falls); end
    checks++;
    if (m_first_fall !== 1 + 2 * P) begin failures++; $display("FAIL write_first_fall got=%0d exp=%0d", m_first_fall, 1 + 2 * P); end
    checks++;
    if (m_sen_low !== 34 * P) begin failures++; $display("FAIL write_sen_low got=%0d exp=%0d", m_sen_low, 34 * P); end
    checks++;
    if (m_done_edge !== 1 + 34 * P) begin failures++; $display("FAIL write_done_edge got=%0d exp=%0d", m_done_edge, 1 + 34 * P); end
    checks++;
    if (m_done_cnt !== 1) begin failures++; $display("FAIL write_done_cnt got=%0d exp=1", m_done_cnt); end
    checks++;
    if (m_busy_at_done !== 1'b0) begin failures++; $display("FAIL write_busy_at_done got=%b exp=0", m_busy_at_done); end
    checks++;
    if (m_rdata_at_done !== model_rdata) begin failures++; $display("FAIL write_rdata got=%h exp=%h", m_rdata_at_done, model_rdata); end
  endtask

  task automatic test_read();
    run_xfer(1'b1, 8'h03, 8'($urandom), 8'hC3, -1, -1);
    model_rdata = 8'hC3;
    checks++;
    if (m_rdata_at_done !== 8'hC3) begin failures++; $display("FAIL read_rdata got=%h exp=c3", m_rdata_at_done); end
    checks++;
    if (m_word !== 16'h0300) begin failures++; $display("FAIL read_bits got=%h exp=0300", m_word); end
    checks++;
    if (m_done_edge !== 1 + 34 * P || m_busy_at_done !== 1'b0) begin
      failures++; $display("FAIL read_done got_edge=%0d busy=%b exp_edge=%0d busy=0", m_done_edge, m_busy_at_done, 1 + 34 * P);
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] a = 8'($urandom), d = 8'($urandom);
    run_xfer(1'b0, a, d, 8'($urandom), 10, -1);
    checks++;
    if (m_done_cnt !== 1 || m_falls !== 16) begin
      failures++; $display("FAIL busy_ignore_counts done=%0d falls=%0d exp=1,16", m_done_cnt, m_falls);
    end
    checks++;
    if (m_word !== {a, d} || m_sen_low !== 34 * P) begin
      failures++; $display("FAIL busy_ignore_frame got=%h sen_low=%0d exp=%h sen_low=%0d", m_word, m_sen_low, {a, d}, 34 * P);
    end
    checks++;
    if (rdata !== model_rdata) begin failures++; $display("FAIL busy_ignore_rdata got=%h exp=%h", rdata, model_rdata); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] a = 8'($urandom), d = 8'($urandom);
    run_xfer(1'b1, 8'h03, 8'h00, 8'($urandom), -1, 20);
    model_rdata = 8'h00;
    checks++;
    if (m_snap !== {6'b110000, 8'h00}) begin failures++; $display("FAIL abort_outputs got=%b exp=%b", m_snap, {6'b110000, 8'h00}); end
    checks++;
    if (m_done_cnt !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", m_done_cnt); end
    wait_idle();
    run_xfer(1'b0, a, d, 8'($urandom), -1, -1);
    checks++;
    if (m_word !== {a, d} || m_done_edge !== 1 + 34 * P) begin
      failures++; $display("FAIL abort_next_write got=%h edge=%0d exp=%h edge=%0d", m_word, m_done_edge, {a, d}, 1 + 34 * P);
    end
    checks++;
    if (m_rdata_at_done !== 8'h00) begin failures++; $display("FAIL abort_rdata got=%h exp=00", m_rdata_at_done); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] wa = 16'($urandom), wb = 16'($urandom);
    logic [31:0] bits = 32'h0;
    logic ps, pc;
    int rise = -1, fall2 = -1, dn = 0, falls = 0;
    @(negedge clk_usb);
    start = 1'b1; rw = 1'b0; addr = wa[15:8]; wdata = wa[7:0];
    @(posedge clk_usb);
    #1 start = 1'b0;
    ps = sen; pc = sclk;
    for (int e = 1; e <= 2 * LEN + 4; e++) begin
      @(posedge clk_usb);
      #1;
      if (start) start = 1'b0;
      if (pc && !sclk) begin bits = {bits[30:0], sdata}; falls++; end
      if (!ps && sen && rise < 0) rise = e;
      if (ps && !sen && rise >= 0 && fall2 < 0) fall2 = e;
      ps = sen; pc = sclk;
      if (done) begin
        dn++;
        if (dn == 1) begin start = 1'b1; rw = 1'b0; addr = wb[15:8]; wdata = wb[7:0]; end
      end
    end
    checks++;
    if (fall2 - rise !== 2) begin failures++; $display("FAIL b2b_gap got=%0d exp=2 (rise=%0d fall=%0d)", fall2 - rise, rise, fall2); end
    checks++;
    if (bits !== {wa, wb} || falls !== 32) begin failures++; $display("FAIL b2b_bits got=%h/%0d exp=%h/32", bits, falls, {wa, wb}); end
    checks++;
    if (dn !== 2) begin failures++; $display("FAIL b2b_done_cnt got=%0d exp=2", dn); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      logic r = 1'($urandom);
      logic [7:0] a = 8'($urandom), d = 8'($urandom), so = 8'($urandom);
      run_xfer(r, a, d, so, -1, -1);
      if (r) model_rdata = so;
      checks++;
      if (m_word !== {a, r ? 8'h00 : d}) begin failures++; $display("FAIL rand_bits[%0d] got=%h exp=%h", i, m_word, {a, r ? 8'h00 : d}); end
      checks++;
      if (m_rdata_at_done !== model_rdata) begin failures++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", i, m_rdata_at_done, model_rdata); end
      checks++;
      if (m_done_edge !== 1 + 34 * P || m_done_cnt !== 1) begin
        failures++; $display("FAIL rand_done[%0d] edge=%0d cnt=%0d exp=%0d,1", i, m_done_edge, m_done_cnt, 1 + 34 * P);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_seq();
    test_write();
    test_read();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
